// File: rtl/fft_r2_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg: shared definitions for the radix-2 DIT FFT sequencer.
//   - state_t      : sequencer FSM states
//   - bfly_addr_t  : butterfly read pair and twiddle index, sized for the
//                    largest legal FFT (LOG2N = 12); callers truncate
//   - bfly_addr()  : address/twiddle generation for stage s, butterfly k
//   - DEFAULT_LOG2N: default FFT size exponent
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DEFAULT_LOG2N = 4;
    localparam int MAX_LOG2N     = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [MAX_LOG2N-1:0] addr0;
        logic [MAX_LOG2N-1:0] addr1;
        logic [MAX_LOG2N-1:0] tw;
    } bfly_addr_t;

    // Butterfly k of stage s pairs the elements that sit one span apart
    // within each group of 2*span; the twiddle step shrinks as span grows.
    function automatic bfly_addr_t bfly_addr(input int unsigned s,
                                             input int unsigned k,
                                             input int unsigned log2n);
        bfly_addr_t  r;
        int unsigned span;
        int unsigned pos;
        int unsigned grp;
        span    = 32'd1 << s;
        pos     = k & (span - 32'd1);
        grp     = k >> s;
        r.addr0 = MAX_LOG2N'((grp << (s + 32'd1)) | pos);
        r.addr1 = MAX_LOG2N'(((grp << (s + 32'd1)) | pos) + span);
        r.tw    = MAX_LOG2N'(pos << (log2n - 32'd1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_r2_sequencer_if.sv
// -----------------------------------------------------------------------------
// fft_r2_sequencer_if: control/RAM-address bundle of the FFT sequencer.
//   start               controller -> sequencer, one-cycle run request
//   busy, done          run status, done is a one-cycle pulse
//   rd_en, rd_addr0/1   butterfly read strobe and leg addresses
//   tw_addr             twiddle ROM index, valid with rd_en
//   wr_en, wr_addr0/1   write-back strobe and addresses (reads delayed)
//   stage               current stage, valid while busy
//   scale               (FFT_SEQ_SCALE_EN only) halve this write's outputs
// modport master = sequencer side, modport slave = FFT controller side.
// -----------------------------------------------------------------------------
interface fft_r2_sequencer_if #(
    parameter int LOG2N = fft_pkg::DEFAULT_LOG2N
);
    localparam int ADDR_W = LOG2N;
    localparam int STG_W  = $clog2(LOG2N + 1);
    localparam int TW_W   = LOG2N - 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [TW_W-1:0]   tw_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [STG_W-1:0]  stage;
`ifdef FFT_SEQ_SCALE_EN
    logic              scale;
`endif

    modport master (
        input  start,
`ifdef FFT_SEQ_SCALE_EN
        output scale,
`endif
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
        output wr_en, wr_addr0, wr_addr1, stage
    );

    modport slave (
        output start,
`ifdef FFT_SEQ_SCALE_EN
        input  scale,
`endif
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_addr,
        input  wr_en, wr_addr0, wr_addr1, stage
    );

endinterface

// File: rtl/fft_r2_sequencer_addr_delay.sv
// -----------------------------------------------------------------------------
// fft_addr_delay: DEPTH-stage register pipe turning the read strobe/addresses
// into the write-back strobe/addresses. Data reads 0 whenever valid is low.
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   read strobe
//   in_data    read addresses (plus optional per-write side bits)
//   out_valid  write strobe, in_valid delayed DEPTH cycles
//   out_data   in_data delayed DEPTH cycles, forced to 0 when not valid
// -----------------------------------------------------------------------------
module fft_addr_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0][W:0] pipe;

    // NOTE: the pipe is reset along with the FSM; an unreset stage could emit a
    // phantom write strobe right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {in_valid, in_data};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[DEPTH-1][W];
    assign out_data  = out_valid ? pipe[DEPTH-1][W-1:0] : '0;

endmodule

// File: rtl/fft_r2_sequencer.sv
// -----------------------------------------------------------------------------
// fft_r2_sequencer: address/control sequencer for an in-place radix-2 DIT FFT
// using one butterfly and one dual-port RAM (data already bit-reversed).
// Per stage it issues N/2 butterfly reads, then idles RD_LAT+1 cycles so the
// stage's last write-backs land before the next stage reads.
//   clk, rst  clock, asynchronous active-high reset
//   bus       fft_r2_sequencer_if.master (start in; status, read, twiddle,
//             write-back addresses and stage out)
// Parameters: LOG2N (2..12), RD_LAT (1..3), SCALE_MASK (FFT_SEQ_SCALE_EN).
// Optional feature macro FFT_SEQ_SCALE_EN: adds bus.scale = SCALE_MASK[stage
// of the write], aligned with wr_en.
// -----------------------------------------------------------------------------
module fft_r2_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N  = DEFAULT_LOG2N,
    parameter int RD_LAT = 1
`ifdef FFT_SEQ_SCALE_EN
    ,
    parameter logic [LOG2N-1:0] SCALE_MASK = '1
`endif
) (
    input logic              clk,
    input logic              rst,
    fft_r2_sequencer_if.master bus
);

    localparam int ADDR_W = LOG2N;
    localparam int STG_W  = $clog2(LOG2N + 1);
    localparam int TW_W   = LOG2N - 1;
    localparam int KW     = LOG2N - 1;

    state_t            state;
    logic [KW-1:0]     k_q;
    logic [1:0]        drain_q;

    logic              k_last;
    logic              drain_last;
    logic              s_last;
    logic              do_issue;
    logic [STG_W-1:0]  issue_s;
    logic [KW-1:0]     issue_k;
    bfly_addr_t        nxt;
    logic              unused_nxt;

    assign k_last     = (k_q == '1);
    assign drain_last = (drain_q == 2'(RD_LAT));
    assign s_last     = (bus.stage == STG_W'(LOG2N - 1));

    // Decide whether the next cycle carries a read, and for which (s, k).
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        do_issue = 1'b0;
        issue_s  = '0;
        issue_k  = '0;
        case (state)
            IDLE: begin
                do_issue = bus.start;
            end
            RUN: begin
                do_issue = !k_last;
                issue_s  = bus.stage;
                issue_k  = k_q + 1'b1;
            end
            DRAIN: begin
                do_issue = drain_last && !s_last;
                issue_s  = bus.stage + 1'b1;
            end
            default: ;
        endcase
        nxt = bfly_addr(32'(issue_s), 32'(issue_k), LOG2N);
    end

    // Upper bits of the max-width address struct are intentionally discarded.
    assign unused_nxt = ^nxt;

    // NOTE: state and registered outputs use non-blocking assignment so every
    // read in this block sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k_q          <= '0;
            drain_q      <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_en    <= 1'b0;
            bus.rd_addr0 <= '0;
            bus.rd_addr1 <= '0;
            bus.tw_addr  <= '0;
            bus.stage    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        k_q      <= '0;
                    end
                end
                RUN: begin
                    if (k_last) begin
                        state   <= DRAIN;
                        drain_q <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!drain_last) begin
                        drain_q <= drain_q + 1'b1;
                    end else if (s_last) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state <= RUN;
                        k_q   <= '0;
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here
                    state     <= IDLE;
                    bus.stage <= '0;
                end
                default: state <= IDLE;
            endcase

            if (do_issue) begin
                bus.rd_en    <= 1'b1;
                bus.rd_addr0 <= ADDR_W'(nxt.addr0);
                bus.rd_addr1 <= ADDR_W'(nxt.addr1);
                bus.tw_addr  <= TW_W'(nxt.tw);
                bus.stage    <= issue_s;
            end else begin
                bus.rd_en    <= 1'b0;
                bus.rd_addr0 <= '0;
                bus.rd_addr1 <= '0;
                bus.tw_addr  <= '0;
            end
        end
    end

    // Write-back path: the read strobe/addresses delayed by the RAM latency.
`ifdef FFT_SEQ_SCALE_EN
    localparam int PW = 2 * ADDR_W + 1;
    logic rd_scale;
    // stage register is aligned with the read it describes
    assign rd_scale = bus.rd_en & (|(SCALE_MASK & (LOG2N'(1) << bus.stage)));
    logic [PW-1:0] pipe_in;
    logic [PW-1:0] pipe_out;
    assign pipe_in = {bus.rd_addr0, bus.rd_addr1, rd_scale};
    assign {bus.wr_addr0, bus.wr_addr1, bus.scale} = pipe_out;
`else
    localparam int PW = 2 * ADDR_W;
    logic [PW-1:0] pipe_in;
    logic [PW-1:0] pipe_out;
    assign pipe_in = {bus.rd_addr0, bus.rd_addr1};
    assign {bus.wr_addr0, bus.wr_addr1} = pipe_out;
`endif

    fft_addr_delay #(
        .DEPTH (RD_LAT),
        .W     (PW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.rd_en),
        .in_data   (pipe_in),
        .out_valid (bus.wr_en),
        .out_data  (pipe_out)
    );

endmodule

// File: tb/tb_fft_r2_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_r2_sequencer: self-checking bench for fft_r2_sequencer (LOG2N=3,
// RD_LAT=1). A cycle-level reference model, built from nested group/position
// loops over each stage, predicts every output; scenarios cover reset, a full
// run, ignored starts, back-to-back runs, async abort and random start traffic.
// With FFT_SEQ_SCALE_EN the DUT uses SCALE_MASK=3'b101.
// -----------------------------------------------------------------------------
module tb_fft_r2_sequencer;
    import fft_pkg::*;

    localparam int LOG2N = 3;
    localparam int RD_LAT = 1;
    localparam int N = 1 << LOG2N;
    localparam int STG_W = $clog2(LOG2N + 1);
    localparam int MAXC = 64;
`ifdef FFT_SEQ_SCALE_EN
    localparam logic [LOG2N-1:0] SCALE_MASK_TB = 3'b101;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fft_r2_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_r2_sequencer #(
        .LOG2N  (LOG2N),
        .RD_LAT (RD_LAT)
`ifdef FFT_SEQ_SCALE_EN
        ,
        .SCALE_MASK (SCALE_MASK_TB)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: expected value per cycle
    bit e_rd_en[MAXC];
    bit e_wr_en[MAXC];
    bit e_busy[MAXC];
    bit e_done[MAXC];
    int e_a0[MAXC];
    int e_a1[MAXC];
    int e_tw[MAXC];
    int e_w0[MAXC];
    int e_w1[MAXC];
    int e_stage[MAXC];
`ifdef FFT_SEQ_SCALE_EN
    bit e_scale[MAXC];
`endif

    // observed trace of the last scenario
    logic             tr_rd_en[MAXC];
    logic             tr_wr_en[MAXC];
    logic [LOG2N-1:0] tr_a0[MAXC];
    logic [LOG2N-1:0] tr_a1[MAXC];
    logic [LOG2N-2:0] tr_tw[MAXC];
    logic [LOG2N-1:0] tr_w0[MAXC];
    logic [LOG2N-1:0] tr_w1[MAXC];

    int rd_cnt, wr_cnt, done_cnt, first_done;

    task automatic add_read(input int t, input int s, input int a0, input int a1, input int tw);
        if (t < MAXC) begin
            e_rd_en[t] = 1'b1;
            e_a0[t] = a0;
            e_a1[t] = a1;
            e_tw[t] = tw;
            e_busy[t] = 1'b1;
            e_stage[t] = s;
        end
        if (t + RD_LAT < MAXC) begin
            e_wr_en[t+RD_LAT] = 1'b1;
            e_w0[t+RD_LAT] = a0;
            e_w1[t+RD_LAT] = a1;
`ifdef FFT_SEQ_SCALE_EN
            e_scale[t+RD_LAT] = SCALE_MASK_TB[s];
`endif
        end
    endtask

    // A start in cycle c (sampled at its closing edge) is honoured only once
    // the previous run has returned to idle, i.e. the cycle after done.
    task automatic build_model(input bit [MAXC-1:0] mask, input int n);
        int t;
        int free_at;
        for (int c = 0; c < MAXC; c++) begin
            e_rd_en[c] = 0; e_wr_en[c] = 0; e_busy[c] = 0; e_done[c] = 0;
            e_a0[c] = 0; e_a1[c] = 0; e_tw[c] = 0; e_w0[c] = 0; e_w1[c] = 0;
            e_stage[c] = 0;
`ifdef FFT_SEQ_SCALE_EN
            e_scale[c] = 0;
`endif
        end
        free_at = 0;
        for (int c = 0; c < n; c++) begin
            if (mask[c] && c >= free_at) begin
                t = c + 1;
                for (int s = 0; s < LOG2N; s++) begin
                    int span = 1 << s;
                    int groups = N / (2 * span);
                    for (int g = 0; g < groups; g++) begin
                        for (int p = 0; p < span; p++) begin
                            add_read(t, s, g * 2 * span + p, g * 2 * span + p + span, p * groups);
                            t++;
                        end
                    end
                    for (int d = 0; d <= RD_LAT; d++) begin
                        if (t < MAXC) begin
                            e_busy[t] = 1'b1;
                            e_stage[t] = s;
                        end
                        t++;
                    end
                end
                if (t < MAXC) e_done[t] = 1'b1;
                free_at = t + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Steps n cycles, driving start from mask and comparing every output of
    // every cycle with the model. Entered and left at 1 time unit past an edge.
    task automatic run_scenario(input string tag, input bit [MAXC-1:0] mask, input int n);
        logic [3:0]       got_ctl, exp_ctl;
        logic [LOG2N-1:0] x0, x1;
        logic [LOG2N-2:0] xt;
        build_model(mask, n);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_done = -1;
        for (int c = 0; c < n; c++) begin
            tr_rd_en[c] = bus.rd_en; tr_wr_en[c] = bus.wr_en;
            tr_a0[c] = bus.rd_addr0; tr_a1[c] = bus.rd_addr1; tr_tw[c] = bus.tw_addr;
            tr_w0[c] = bus.wr_addr0; tr_w1[c] = bus.wr_addr1;
            if (bus.rd_en === 1'b1) rd_cnt++;
            if (bus.wr_en === 1'b1) wr_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end

            got_ctl = {bus.rd_en, bus.busy, bus.done, bus.wr_en};
            exp_ctl = {e_rd_en[c], e_busy[c], e_done[c], e_wr_en[c]};
            vectors++;
            if (got_ctl !== exp_ctl) begin
                miscompares++;
                $display("FAIL %s cyc %0d ctl{rd,busy,done,wr} got %b want %b", tag, c, got_ctl, exp_ctl);
            end
            x0 = LOG2N'(e_w0[c]); x1 = LOG2N'(e_w1[c]);
            vectors++;
            if (bus.wr_addr0 !== x0 || bus.wr_addr1 !== x1) begin
                miscompares++;
                $display("FAIL %s cyc %0d wr_addr got (%0d,%0d) want (%0d,%0d)",
                         tag, c, bus.wr_addr0, bus.wr_addr1, x0, x1);
            end
            if (e_rd_en[c]) begin
                x0 = LOG2N'(e_a0[c]); x1 = LOG2N'(e_a1[c]); xt = (LOG2N-1)'(e_tw[c]);
                vectors++;
                if (bus.rd_addr0 !== x0 || bus.rd_addr1 !== x1 || bus.tw_addr !== xt) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d rd_addr/tw got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                             tag, c, bus.rd_addr0, bus.rd_addr1, bus.tw_addr, x0, x1, xt);
                end
            end
            if (e_busy[c]) begin
                vectors++;
                if (bus.stage !== STG_W'(e_stage[c])) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d stage got %0d want %0d", tag, c, bus.stage, e_stage[c]);
                end
            end
`ifdef FFT_SEQ_SCALE_EN
            if (e_wr_en[c]) begin
                vectors++;
                if (bus.scale !== e_scale[c]) begin
                    miscompares++;
                    $display("FAIL %s cyc %0d scale got %b want %b", tag, c, bus.scale, e_scale[c]);
                end
            end
`endif
            bus.start = mask[c];
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] snap;
        snap = 32'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr0, bus.rd_addr1,
                    bus.tw_addr, bus.wr_addr0, bus.wr_addr1, bus.stage});
        vectors++;
        if (snap !== 32'd0) begin
            miscompares++;
            $display("FAIL %s outputs got %h want 0", tag, snap);
        end
`ifdef FFT_SEQ_SCALE_EN
        vectors++;
        if (bus.scale !== 1'b0) begin
            miscompares++;
            $display("FAIL %s scale got %b want 0", tag, bus.scale);
        end
`endif
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset_async");   // before the first clock edge
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int exp_rd;
        int exp_done;
        exp_rd = LOG2N * N / 2;
        exp_done = 1 + LOG2N * (N / 2 + RD_LAT + 1);
        do_reset();
        run_scenario("full", 64'h1, 24);
        vectors++;
        if (rd_cnt != exp_rd || wr_cnt != exp_rd) begin
            miscompares++;
            $display("FAIL full_counts rd %0d wr %0d want %0d each", rd_cnt, wr_cnt, exp_rd);
        end
        vectors++;
        if (done_cnt != 1 || first_done != exp_done) begin
            miscompares++;
            $display("FAIL full_done count %0d at %0d want 1 at %0d", done_cnt, first_done, exp_done);
        end
        vectors++;
        if (tr_rd_en[0] !== 1'b0 || tr_rd_en[1] !== 1'b1 || tr_a0[1] !== 3'd0 || tr_a1[1] !== 3'd1 || tr_tw[1] !== 2'd0) begin
            miscompares++;
            $display("FAIL full_first_read en0 %b en1 %b got (%0d,%0d,%0d) want (0,1,0)",
                     tr_rd_en[0], tr_rd_en[1], tr_a0[1], tr_a1[1], tr_tw[1]);
        end
        vectors++;
        if (tr_a0[4] !== 3'd6 || tr_a1[4] !== 3'd7 || tr_tw[4] !== 2'd0) begin
            miscompares++;
            $display("FAIL full_s0k3 got (%0d,%0d,%0d) want (6,7,0)", tr_a0[4], tr_a1[4], tr_tw[4]);
        end
        vectors++;
        if (tr_a0[8] !== 3'd1 || tr_a1[8] !== 3'd3 || tr_tw[8] !== 2'd2) begin
            miscompares++;
            $display("FAIL full_s1k1 got (%0d,%0d,%0d) want (1,3,2)", tr_a0[8], tr_a1[8], tr_tw[8]);
        end
        vectors++;
        if (tr_a0[16] !== 3'd3 || tr_a1[16] !== 3'd7 || tr_tw[16] !== 2'd3) begin
            miscompares++;
            $display("FAIL full_s2k3 got (%0d,%0d,%0d) want (3,7,3)", tr_a0[16], tr_a1[16], tr_tw[16]);
        end
        vectors++;
        if (tr_wr_en[5] !== 1'b1 || tr_w0[5] !== 3'd6 || tr_w1[5] !== 3'd7) begin
            miscompares++;
            $display("FAIL full_last_s0_write en %b got (%0d,%0d) want 1 (6,7)", tr_wr_en[5], tr_w0[5], tr_w1[5]);
        end
        vectors++;
        if (tr_rd_en[5] !== 1'b0 || tr_rd_en[6] !== 1'b0 || tr_rd_en[11] !== 1'b0 ||
            tr_rd_en[12] !== 1'b0 || tr_rd_en[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drain rd_en 5,6,11,12,7 got %b%b%b%b%b want 00001",
                     tr_rd_en[5], tr_rd_en[6], tr_rd_en[11], tr_rd_en[12], tr_rd_en[7]);
        end
    endtask

    task automatic test_start_ignored();
        bit [MAXC-1:0] mask;
        mask = '0;
        mask[0] = 1'b1; mask[4] = 1'b1; mask[19] = 1'b1; mask[21] = 1'b1;
        do_reset();
        run_scenario("ignored", mask, 45);
        vectors++;
        if (done_cnt != 2 || first_done != 19) begin
            miscompares++;
            $display("FAIL ignored_done count %0d first %0d want 2 first 19", done_cnt, first_done);
        end
        vectors++;
        if (tr_rd_en[20] !== 1'b0 || tr_rd_en[21] !== 1'b0 || tr_rd_en[22] !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_restart rd_en 20,21,22 got %b%b%b want 001",
                     tr_rd_en[20], tr_rd_en[21], tr_rd_en[22]);
        end
    endtask

    task automatic test_back_to_back();
        bit [MAXC-1:0] mask;
        mask = '0;
        mask[0] = 1'b1; mask[20] = 1'b1;
        do_reset();
        run_scenario("b2b", mask, 42);
        vectors++;
        if (done_cnt != 2 || tr_rd_en[21] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b done count %0d rd_en21 %b want 2 and 1", done_cnt, tr_rd_en[21]);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        run_scenario("abort_pre", 64'h1, 9);   // now inside cycle 9
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort_async");
        @(posedge clk);
        #1;
        check_all_zero("abort_held");
        rst = 1'b0;
        run_scenario("abort_post", 64'h1, 24);
        vectors++;
        if (done_cnt != 1 || first_done != 19) begin
            miscompares++;
            $display("FAIL abort_post_done count %0d at %0d want 1 at 19", done_cnt, first_done);
        end
    endtask

    task automatic test_random();
        bit [MAXC-1:0] mask;
        bfly_addr_t r;
        for (int it = 0; it < 8; it++) begin
            mask = '0;
            for (int c = 0; c < MAXC; c++) mask[c] = ($urandom_range(0, 5) == 0);
            do_reset();
            run_scenario("rand", mask, MAXC);
        end
        // package address function against the group/position view
        for (int it = 0; it < 16; it++) begin
            int s, span, g, p;
            s = $urandom_range(0, LOG2N - 1);
            span = 1 << s;
            g = $urandom_range(0, N / (2 * span) - 1);
            p = $urandom_range(0, span - 1);
            r = bfly_addr(32'(g * span + p), 32'(s) == 0 ? 32'(g * span + p) : 32'(g * span + p), LOG2N);
            r = bfly_addr(32'(s), 32'(g * span + p), LOG2N);
            vectors++;
            if (int'(r.addr0) != g * 2 * span + p || int'(r.addr1) != g * 2 * span + p + span ||
                int'(r.tw) != p * (N / (2 * span))) begin
                miscompares++;
                $display("FAIL pkg_addr s %0d g %0d p %0d got (%0d,%0d,%0d)", s, g, p, r.addr0, r.addr1, r.tw);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_full_run();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
